// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle register-reference ops on ac/e, skip tests,
// and an optional WIDTH-cycle unsigned shift-add multiply.
module acc_alu #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       code,
  input  logic [WIDTH-1:0] dr,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             skip,
  output logic             busy,
  output logic             done
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_ac;
  logic                 r_e;
  logic                 r_skip;
  logic                 r_done;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_prod;

  logic [WIDTH-1:0]     w_ac_nxt;
  logic                 w_e_nxt;
  logic                 w_skip_nxt;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_inc;
  logic                 w_is_mul;
  logic [2*WIDTH-1:0]   w_prod_nxt;

  assign w_sum      = {1'b0, r_ac} + {1'b0, dr};
  assign w_inc      = {1'b0, r_ac} + {{WIDTH{1'b0}}, 1'b1};
  assign w_is_mul   = MUL_EN && (code == 4'b1110);
  // Multiplicand shifts left and multiplier right, so bit 0 always selects.
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_ac_nxt   = r_ac;
    w_e_nxt    = r_e;
    w_skip_nxt = 1'b0;
    case (code)
      4'b0000: w_ac_nxt = r_ac & dr;
      4'b0001: {w_e_nxt, w_ac_nxt} = w_sum;
      4'b0010: w_ac_nxt = dr;
      4'b0011: w_ac_nxt = ~r_ac;
      4'b0100: begin w_ac_nxt = {r_e, r_ac[WIDTH-1:1]}; w_e_nxt = r_ac[0]; end
      4'b0101: begin w_ac_nxt = {r_ac[WIDTH-2:0], r_e}; w_e_nxt = r_ac[WIDTH-1]; end
      4'b0110: w_ac_nxt = '0;
      4'b0111: {w_e_nxt, w_ac_nxt} = w_inc;
      4'b1000: w_e_nxt = 1'b0;
      4'b1001: w_e_nxt = ~r_e;
      4'b1010: w_skip_nxt = ~r_ac[WIDTH-1];
      4'b1011: w_skip_nxt = r_ac[WIDTH-1];
      4'b1100: w_skip_nxt = (r_ac == '0);
      4'b1101: w_skip_nxt = ~r_e;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ac     <= '0;
      r_e      <= 1'b0;
      r_skip   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else begin
      r_done <= 1'b0;
      r_skip <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_is_mul) begin
            r_state  <= S_MUL;
            r_mcand  <= {{WIDTH{1'b0}}, r_ac};
            r_mplier <= dr;
            r_prod   <= '0;
            r_cnt    <= '0;
          end else begin
            r_ac   <= w_ac_nxt;
            r_e    <= w_e_nxt;
            r_skip <= w_skip_nxt;
            r_done <= 1'b1;
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // ac/e stay untouched until the last bit is folded in.
          if (r_cnt == LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ac    <= w_prod_nxt[WIDTH-1:0];
            r_e     <= |w_prod_nxt[2*WIDTH-1:WIDTH];
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ac   = r_ac;
  assign e    = r_e;
  assign skip = r_skip;
  assign done = r_done;
  assign busy = (r_state == S_MUL);

endmodule

// File: tb/tb_acc_alu.sv
// Directed bench for acc_alu: WIDTH 16/8/32 with MUL, plus WIDTH 16 without MUL,
// all driven by one shared command stream with per-instance operands.
module tb_acc_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  code = 4'h0;
  logic [15:0] d16 = '0, dn = '0;
  logic [7:0]  d8 = '0;
  logic [31:0] d32 = '0;

  logic [15:0] ac16, acn;
  logic [7:0]  ac8;
  logic [31:0] ac32;
  logic [3:0]  e_v, skip_v, busy_v, done_v;

  int n_chk = 0;
  int n_fail = 0;
  int nb[4], nd[4], fd[4];
  int bad_hold, collide, dcnt;

  always #5 clk = ~clk;

  acc_alu #(.WIDTH(16), .MUL_EN(1'b1)) u16 (.clk(clk), .rst(rst), .start(start), .code(code),
    .dr(d16), .ac(ac16), .e(e_v[0]), .skip(skip_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  acc_alu #(.WIDTH(8), .MUL_EN(1'b1)) u8 (.clk(clk), .rst(rst), .start(start), .code(code),
    .dr(d8), .ac(ac8), .e(e_v[1]), .skip(skip_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  acc_alu #(.WIDTH(32), .MUL_EN(1'b1)) u32 (.clk(clk), .rst(rst), .start(start), .code(code),
    .dr(d32), .ac(ac32), .e(e_v[2]), .skip(skip_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  acc_alu #(.WIDTH(16), .MUL_EN(1'b0)) un (.clk(clk), .rst(rst), .start(start), .code(code),
    .dr(dn), .ac(acn), .e(e_v[3]), .skip(skip_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command; returns 1ns after the accepting edge.
  task automatic cmd(input logic [3:0] c, input logic [31:0] v16, input logic [31:0] v8,
                     input logic [31:0] v32);
    code = c; d16 = v16[15:0]; dn = v16[15:0]; d8 = v8[7:0]; d32 = v32;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] v16, input logic [31:0] v8, input logic [31:0] v32,
                         input logic [15:0] hold16);
    for (int k = 0; k < 4; k++) begin nb[k] = 0; nd[k] = 0; fd[k] = -1; end
    bad_hold = 0; collide = 0;
    cmd(4'b1110, v16, v8, v32);
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (busy_v[k]) nb[k]++;
        if (done_v[k]) begin nd[k]++; if (fd[k] < 0) fd[k] = i; end
        if ((busy_v[k] && (done_v[k] || skip_v[k]))) collide++;
      end
      if (busy_v[0] && (ac16 !== hold16)) bad_hold++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ac16", ac16, 16'h0);
    chk("rst_flags", {e_v, skip_v, busy_v, done_v}, 16'h0);
    rst = 1'b0;

    // Carry out of ADD at every width
    cmd(4'b0010, 32'hFFFF, 32'hFF, 32'hFFFF_FFFF);
    chk("lda_ac16", ac16, 16'hFFFF);
    chk("lda_done", done_v, 4'hF);
    cmd(4'b0001, 1, 1, 1);
    chk("add_ac16", ac16, 16'h0);
    chk("add_ac8", ac8, 8'h0);
    chk("add_ac32", ac32, 32'h0);
    chk("add_acn", acn, 16'h0);
    chk("add_e", e_v, 4'hF);
    chk("add_done", done_v, 4'hF);

    // Link manipulation and rotates
    cmd(4'b1000, 0, 0, 0);
    chk("cle_e", e_v[0], 1'b0);
    cmd(4'b1001, 0, 0, 0);
    chk("cme_e", e_v[0], 1'b1);
    cmd(4'b0010, 1, 1, 1);
    cmd(4'b0100, 0, 0, 0);
    chk("cir_ac", ac16, 16'h8000);
    chk("cir_e", e_v[0], 1'b1);
    cmd(4'b0101, 0, 0, 0);
    chk("cil_ac", ac16, 16'h0001);
    chk("cil_e", e_v[0], 1'b1);

    // Skip tests
    cmd(4'b0110, 0, 0, 0);
    chk("cla_ac", ac16, 16'h0);
    cmd(4'b1100, 0, 0, 0);
    chk("sza_skip", {skip_v[0], done_v[0]}, 2'b11);
    @(posedge clk); #1;
    chk("sza_pulse", {skip_v[0], done_v[0]}, 2'b00);
    cmd(4'b0010, 32'h8000, 0, 0);
    cmd(4'b1011, 0, 0, 0);
    chk("sna_skip", skip_v[0], 1'b1);
    chk("sna_ac_e", {ac16, e_v[0]}, {16'h8000, 1'b1});
    cmd(4'b1010, 0, 0, 0);
    chk("spa_skip", {skip_v[0], done_v[0]}, 2'b01);
    cmd(4'b1101, 0, 0, 0);
    chk("sze_e1", skip_v[0], 1'b0);
    cmd(4'b1000, 0, 0, 0);
    cmd(4'b1101, 0, 0, 0);
    chk("sze_e0", skip_v[0], 1'b1);

    // Logic, increment wrap, NOP
    cmd(4'b0010, 32'hF0F0, 0, 0);
    cmd(4'b0000, 32'h3C3C, 0, 0);
    chk("and_ac_e", {ac16, e_v[0]}, {16'h3030, 1'b0});
    cmd(4'b0010, 32'hFFFF, 0, 0);
    cmd(4'b0111, 0, 0, 0);
    chk("inc_wrap", {ac16, e_v[0]}, {16'h0000, 1'b1});
    cmd(4'b0111, 0, 0, 0);
    chk("inc_nowrap", {ac16, e_v[0]}, {16'h0001, 1'b0});
    cmd(4'b1111, 0, 0, 0);
    chk("nop", {ac16, e_v[0], done_v[0], skip_v[0]}, {16'h0001, 1'b0, 1'b1, 1'b0});

    // 3 * 5 without overflow
    cmd(4'b0010, 3, 3, 3);
    run_mul(5, 5, 5, 16'h0003);
    chk("mul_busy16", nb[0], 16);
    chk("mul_busy8", nb[1], 8);
    chk("mul_busy32", nb[2], 32);
    chk("mul_busyn", nb[3], 0);
    chk("mul_done_cnt", {nd[0][7:0], nd[1][7:0], nd[2][7:0], nd[3][7:0]}, 32'h01010101);
    chk("mul_done_at16", fd[0], 16);
    chk("mul_done_at8", fd[1], 8);
    chk("mul_done_at32", fd[2], 32);
    chk("mul_done_atn", fd[3], 0);
    chk("mul_hold", bad_hold, 0);
    chk("mul_collide", collide, 0);
    chk("mul_ac16", {ac16, e_v[0]}, {16'h000F, 1'b0});
    chk("mul_ac8", {ac8, e_v[1]}, {8'h0F, 1'b0});
    chk("mul_ac32", {ac32, e_v[2]}, {32'h0000_000F, 1'b0});
    chk("mul_acn", acn, 16'h0003);

    // Product overflows into the high half
    cmd(4'b0010, 32'h100, 32'h10, 32'h1_0000);
    run_mul(32'h100, 32'h10, 32'h1_0000, 16'h0100);
    chk("ovf_ac16", {ac16, e_v[0]}, {16'h0000, 1'b1});
    chk("ovf_ac8", {ac8, e_v[1]}, {8'h00, 1'b1});
    chk("ovf_ac32", {ac32, e_v[2]}, {32'h0, 1'b1});
    chk("ovf_acn", acn, 16'h0100);
    chk("ovf_done16", nd[0], 1);

    // Start ignored while busy, then reset aborts the multiply
    cmd(4'b0010, 32'h1234, 0, 0);
    cmd(4'b1001, 0, 0, 0);
    dcnt = 0;
    cmd(4'b1110, 7, 7, 7);
    for (int i = 1; i < 5; i++) begin
      if (done_v[0]) dcnt++;
      @(posedge clk); #1;
    end
    cmd(4'b0110, 0, 0, 0);
    chk("ign_ac", {ac16, busy_v[0]}, {16'h1234, 1'b1});
    for (int i = 6; i < 8; i++) begin
      if (done_v[0]) dcnt++;
      @(posedge clk); #1;
    end
    start = 1'b1; code = 4'b0010; d16 = 16'hBEEF;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("abort_state", {ac16, e_v[0], busy_v[0], done_v[0], skip_v[0]}, {16'h0, 4'b0000});
    for (int i = 0; i < 20; i++) begin
      if (done_v[0] || busy_v[0]) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort_nodone", dcnt, 0);
    chk("abort_ac", ac16, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_alu.md
ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal range 4..32.
REQ-002 Parameter MUL_EN, default 1; 1 = multi-cycle MUL implemented, 0 = code 1110 treated as NOP.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  command strobe; sampled only when busy=0.
REQ-006 code  input  4  operation code, sampled with start.
REQ-007 dr  input  WIDTH  memory-data operand, sampled with start.
REQ-008 ac  output  WIDTH  accumulator register.
REQ-009 e  output  1  E (carry/link) flag register.
REQ-010 skip  output  1  one-cycle skip-next-instruction pulse for the PC.
REQ-011 busy  output  1  high while a multi-cycle operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse per accepted command.

Function
REQ-013 Command accepted at a rising edge where start=1 and busy=0; start while busy=1 is ignored, with no queuing.
REQ-014 Single-cycle ops update ac/e at the accepting edge; done, and skip when applicable, are high for exactly the following cycle.
REQ-015 0000 AND: ac=ac&dr; e unchanged.
REQ-016 0001 ADD: {e,ac}=ac+dr as a WIDTH+1-bit unsigned sum.
REQ-017 0010 LDA: ac=dr; e unchanged.
REQ-018 0011 CMA: ac=~ac; e unchanged.
REQ-019 0100 CIR: ac={e,ac[WIDTH-1:1]}, e=old ac[0].
REQ-020 0101 CIL: ac={ac[WIDTH-2:0],e}, e=old ac[WIDTH-1].
REQ-021 0110 CLA: ac=0; e unchanged.
REQ-022 0111 INC: {e,ac}=ac+1; e=1 only on wrap from all-ones.
REQ-023 1000 CLE: e=0.
REQ-024 1001 CME: e=~e.
REQ-025 1010 SPA: skip=~ac[WIDTH-1].
REQ-026 1011 SNA: skip=ac[WIDTH-1].
REQ-027 1100 SZA: skip=(ac==0).
REQ-028 1101 SZE: skip=~e.
REQ-029 For 1010-1101, ac and e are unchanged and skip is evaluated on pre-edge values.
REQ-030 1110 MUL (MUL_EN=1), unsigned shift-add: at the accepting edge, latch multiplicand=ac, multiplier=dr, clear a 2*WIDTH partial product and the iteration counter, set busy=1.
REQ-031 MUL: FSM IDLE->MUL on acceptance; one multiplier bit per cycle for exactly WIDTH cycles; MUL->IDLE at edge k+WIDTH (k = accepting edge).
REQ-032 MUL: at edge k+WIDTH, write ac=low WIDTH bits of the product, e=1 iff the high WIDTH bits are nonzero, and drop busy; done is high in the next cycle.
REQ-033 ac and e hold their pre-command values throughout MUL until edge k+WIDTH.
REQ-034 1111, and 1110 with MUL_EN=0: NOP; ac/e unchanged, done pulses.
REQ-035 skip is 0 for every code other than 1010-1101; done and skip are never high while busy=1.
REQ-036 A new command may be accepted in the same cycle that done is high.

Reset
REQ-037 rst=1 at an edge forces ac=0, e=0, skip=0, busy=0, done=0, FSM=IDLE, counter=0.
REQ-038 Reset has priority over start.
REQ-039 Reset mid-MUL aborts the operation with no done pulse and no partial result on ac.

Verification
REQ-040 WIDTH=16: LDA dr=0xFFFF, then ADD dr=0x0001 -> ac=0x0000, e=1, done one cycle after each command.
REQ-041 CME from e=0 (e=1), LDA 0x0001, CIR -> ac=0x8000, e=1; then CIL -> ac=0x0001, e=1.
REQ-042 ac=0x0003, MUL dr=0x0005 -> busy high 16 cycles, ac=0x000F, e=0, single done pulse; ac=0x0100, MUL dr=0x0100 -> ac=0x0000, e=1.
REQ-043 CLA then SZA -> skip=1 for one cycle; LDA 0x8000 then SNA -> skip=1, SPA -> skip=0; ac/e unchanged by the skips.
REQ-044 Start MUL, pulse start with CLA at cycle 5 (ignored), assert rst at cycle 8 -> ac=0, e=0, busy=0, no done.
REQ-045 Repeat REQ-040 and REQ-042 at WIDTH=8 and WIDTH=32; with MUL_EN=0, code 1110 -> ac unchanged, done after one cycle, busy never high.
